// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register built as a two-entry skid buffer (head drives MEM, skid absorbs one stall).
// Latency: 1 cycle from accept to out_valid when the head is empty.
// Backpressure: in_ready is a pure register decode (!skid_valid), so there is no path from out_ready.
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int BR_BIT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WB_W-1:0]    ctlwb_out,
    input  logic [M_W-1:0]     ctlm_out,
    input  logic [DATA_W-1:0]  adder_out,
    input  logic [DATA_W-1:0]  aluout,
    input  logic [DATA_W-1:0]  readdat2,
    input  logic               aluzero,
    input  logic [RADDR_W-1:0] muxout,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WB_W-1:0]    wb_ctlout,
    output logic [M_W-1:0]     m_ctlout,
    output logic [DATA_W-1:0]  add_result,
    output logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  rdata2out,
    output logic               zero,
    output logic [RADDR_W-1:0] wreg_out,
    output logic               branch_taken,
    output logic [1:0]         occupancy,
    output logic [15:0]        stall_cnt
);

    typedef struct packed {
        logic [WB_W-1:0]    wb;
        logic [M_W-1:0]     m;
        logic [DATA_W-1:0]  add;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  rd2;
        logic               zero;
        logic [RADDR_W-1:0] wreg;
    } ent_t;

    ent_t        r_head;
    ent_t        r_skid;
    logic        r_head_vld;
    logic        r_skid_vld;
    logic [15:0] r_stall_cnt;

    ent_t w_in;
    logic w_accept;
    logic w_pop;

    assign w_in     = '{wb: ctlwb_out, m: ctlm_out, add: adder_out, alu: aluout,
                        rd2: readdat2, zero: aluzero, wreg: muxout};
    assign in_ready = ~r_skid_vld;
    assign w_accept = in_valid & in_ready;
    assign w_pop    = r_head_vld & out_ready;

    // The skid is only ever filled while the head is held, so an empty head implies an empty skid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_skid     <= '0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_head_vld) begin
            if (w_accept) begin
                r_head     <= w_in;
                r_head_vld <= 1'b1;
            end
        end else if (w_pop) begin
            if (r_skid_vld) begin
                r_head     <= r_skid;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_head <= w_in;
            end else begin
                r_head_vld <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_head_vld && !out_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid    = r_head_vld;
    assign wb_ctlout    = r_head_vld ? r_head.wb : '0;
    assign m_ctlout     = r_head_vld ? r_head.m  : '0;
    assign add_result   = r_head.add;
    assign alu_result   = r_head.alu;
    assign rdata2out    = r_head.rd2;
    assign zero         = r_head.zero;
    assign wreg_out     = r_head.wreg;
    assign branch_taken = r_head_vld & r_head.m[BR_BIT] & r_head.zero;
    assign occupancy    = {1'b0, r_head_vld} + {1'b0, r_skid_vld};
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed and randomised checks of the EX/MEM skid-buffer pipeline register.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  ctlwb_out;
    logic [2:0]  ctlm_out;
    logic [31:0] adder_out, aluout, readdat2;
    logic        aluzero;
    logic [4:0]  muxout;
    logic        flush;
    logic        out_valid, out_ready;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result, alu_result, rdata2out;
    logic        zero;
    logic [4:0]  wreg_out;
    logic        branch_taken;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ex_mem_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
        .aluout(aluout), .readdat2(readdat2), .aluzero(aluzero), .muxout(muxout),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
        .alu_result(alu_result), .rdata2out(rdata2out), .zero(zero),
        .wreg_out(wreg_out), .branch_taken(branch_taken), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                         input logic [31:0] ad, input logic [31:0] al, input logic [31:0] rd,
                         input logic z, input logic [4:0] wr);
        in_valid = v; ctlwb_out = wb; ctlm_out = m; adder_out = ad;
        aluout = al; readdat2 = rd; aluzero = z; muxout = wr;
    endtask

    function automatic logic [127:0] head_word();
        return {21'd0, wb_ctlout, m_ctlout, add_result, alu_result, rdata2out, zero, wreg_out};
    endfunction

    logic [127:0] q[$];
    logic [127:0] w;
    int sent, got, cyc;

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_wb_m", {wb_ctlout, m_ctlout}, 0);
        tick();
        reset = 1'b1;

        // pass-through, first accept right after reset release
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 3'b111, 32'd12, 32'd15, 32'd10, 1'b0, 5'd31);
        tick();
        chk("pt_out_valid", out_valid, 1);
        chk("pt_fields", head_word(), {21'd0, 2'b10, 3'b111, 32'd12, 32'd15, 32'd10, 1'b0, 5'd31});
        chk("pt_branch", branch_taken, 0);
        in_valid = 1'b0;
        tick();
        chk("pt_empty", out_valid, 0);
        chk("bubble_ctl", {wb_ctlout, m_ctlout}, 0);

        // branch decode; second entry replaces head on the same edge as the pop
        drive(1'b1, 2'b00, 3'b100, 32'd40, 32'd0, 32'd0, 1'b1, 5'd1);
        tick();
        chk("br_taken", branch_taken, 1);
        drive(1'b1, 2'b00, 3'b100, 32'd44, 32'd7, 32'd0, 1'b0, 5'd2);
        tick();
        chk("br_not_taken", branch_taken, 0);
        chk("br_replace_alu", alu_result, 7);
        in_valid = 1'b0;
        tick();
        chk("br_empty", occupancy, 0);

        // back-pressure
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 3'b000, 32'd0, 32'd1, 32'd0, 1'b0, 5'd3);
        tick();
        chk("bp_occ1", occupancy, 1);
        chk("bp_stall0", stall_cnt, 0);
        aluout = 32'd2;
        tick();
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready0", in_ready, 0);
        in_valid = 1'b0;
        tick();
        chk("bp_stall2", stall_cnt, 2);
        chk("bp_head_A", alu_result, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_head_B", alu_result, 2);
        chk("bp_in_ready1", in_ready, 1);
        chk("bp_occ_after", occupancy, 1);
        tick();
        chk("bp_drained", occupancy, 0);
        chk("bp_stall_hold", stall_cnt, 2);

        // flush with two entries plus an offered input
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 3'b011, 32'd0, 32'd3, 32'd0, 1'b0, 5'd4);
        tick();
        aluout = 32'd4;
        tick();
        chk("fl_occ2", occupancy, 2);
        flush = 1'b1; aluout = 32'd5;
        tick();
        chk("fl_occ0", occupancy, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_ctl", {wb_ctlout, m_ctlout}, 0);
        chk("fl_stall", stall_cnt, 4);
        // flush must discard an accept on the same edge
        flush = 1'b0; aluout = 32'd6;
        tick();
        flush = 1'b1; aluout = 32'd7;
        tick();
        chk("fl_accept_drop", occupancy, 0);
        flush = 1'b0;

        // async reset between edges with two entries held
        aluout = 32'd8;
        tick();
        aluout = 32'd9;
        tick();
        in_valid = 1'b0;
        chk("ar_occ2", occupancy, 2);
        #2 reset = 1'b0;
        #1;
        chk("ar_occ0", occupancy, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_alu", alu_result, 0);
        chk("ar_stall", stall_cnt, 0);
        chk("ar_in_ready", in_ready, 1);
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 3'b001, 32'd0, 32'd10, 32'd0, 1'b0, 5'd9);
        tick();
        chk("ar_first_accept", alu_result, 10);
        chk("ar_first_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // randomised valid/ready against a reference queue
        sent = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ctlwb_out = 2'($urandom); ctlm_out = 3'($urandom);
            adder_out = $urandom; aluout = $urandom; readdat2 = $urandom;
            aluzero = 1'($urandom); muxout = 5'($urandom);
            #1;
            if (out_valid && out_ready) begin
                w = q.pop_front();
                chk("rnd_entry", head_word(), w);
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({21'd0, ctlwb_out, ctlm_out, adder_out, aluout, readdat2, aluzero, muxout});
                sent++;
            end
            tick();
            cyc++;
        end
        chk("rnd_count", got, 1000);
        chk("rnd_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
